// File: rtl/sprite_engine_if.sv
// Sprite engine bus: register/texture write port, frame commit strobe,
// coordinate stream in and composed pixel stream out.
interface sprite_engine_if #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned INT_WIDTH   = 16,
    parameter int unsigned COLOR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [INT_WIDTH-1:0]   wdata;
    logic                   wen;
    logic                   commit;
    logic                   in_valid;
    logic [INT_WIDTH-1:0]   x;
    logic [INT_WIDTH-1:0]   y;
    logic                   out_valid;
    logic [COLOR_WIDTH-1:0] pixel;

    modport master (
        output waddr, wdata, wen, commit, in_valid, x, y,
        input  out_valid, pixel
    );

    modport slave (
        input  waddr, wdata, wen, commit, in_valid, x, y,
        output out_valid, pixel
    );
endinterface

// File: rtl/sprite_engine.sv
// Pipelined sprite compositor: one screen coordinate in, one pixel out,
// fixed 3-cycle latency. Sprite/background registers are double-buffered
// (shadow written by the bus, active loaded on commit); the texture RAM is
// written directly. Optional feature macro: SPRITE_ENGINE_COLOR_KEY_EN adds
// a shadowed colour-key register at BG_ADDR+1 that makes matching texels
// show the background.
module sprite_engine #(
    parameter int unsigned NUM_SPRITES    = 16,
    parameter int unsigned TEXTURE_WIDTH  = 64,
    parameter int unsigned TEXTURE_HEIGHT = 64,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned INT_WIDTH      = 16,
    parameter int unsigned COLOR_WIDTH    = 12
) (
    input  logic           clk,
    input  logic           rst,
    sprite_engine_if.slave bus
);

    localparam int unsigned EXT_PAD   = 4;
    localparam int unsigned EXT_W     = INT_WIDTH + EXT_PAD;
    localparam int unsigned IDX_W     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int unsigned TEX_DEPTH = TEXTURE_WIDTH * TEXTURE_HEIGHT;
    localparam int unsigned RA_W      = $clog2(TEX_DEPTH);
    localparam int unsigned BG_ADDR   = NUM_SPRITES * 8;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
    localparam int unsigned KEY_ADDR  = BG_ADDR + 1;
`endif
    localparam int unsigned TEX_BASE  = BG_ADDR + 8;

    typedef struct packed {
        logic [INT_WIDTH-1:0] sx;
        logic [INT_WIDTH-1:0] sy;
        logic [INT_WIDTH-1:0] tx;
        logic [INT_WIDTH-1:0] ty;
        logic [INT_WIDTH-1:0] tw;
        logic [INT_WIDTH-1:0] th;
        logic                 flip_y;
        logic                 flip_x;
        logic [1:0]           scale;
        logic                 en;
    } sprite_regs_t;

    // ---------------- register file ----------------
    sprite_regs_t           r_shadow [NUM_SPRITES];
    sprite_regs_t           r_active [NUM_SPRITES];
    logic [COLOR_WIDTH-1:0] r_bg_sh;
    logic [COLOR_WIDTH-1:0] r_bg_act;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
    logic [COLOR_WIDTH-1:0] r_key_sh;
    logic [COLOR_WIDTH-1:0] r_key_act;
    logic                   w_key_sel;
`endif

    logic                   w_spr_sel;
    logic                   w_bg_sel;
    logic                   w_tex_sel;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [2:0]             w_wr_field;
    logic [ADDR_WIDTH-1:0]  w_tex_off;

    assign w_spr_sel  = bus.wen && (bus.waddr < ADDR_WIDTH'(BG_ADDR));
    assign w_bg_sel   = bus.wen && (bus.waddr == ADDR_WIDTH'(BG_ADDR));
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
    assign w_key_sel  = bus.wen && (bus.waddr == ADDR_WIDTH'(KEY_ADDR));
`endif
    assign w_tex_off  = bus.waddr - ADDR_WIDTH'(TEX_BASE);
    assign w_tex_sel  = bus.wen && (bus.waddr >= ADDR_WIDTH'(TEX_BASE))
                        && (w_tex_off < ADDR_WIDTH'(TEX_DEPTH));
    assign w_wr_idx   = bus.waddr[IDX_W+2:3];
    assign w_wr_field = bus.waddr[2:0];

    // Shadow writes from the bus; commit copies the pre-edge shadow to active
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_bg_sh  <= '0;
            r_bg_act <= '0;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
            r_key_sh  <= '0;
            r_key_act <= '0;
`endif
        end else begin
            if (bus.commit) begin
                r_active <= r_shadow;
                r_bg_act <= r_bg_sh;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
                r_key_act <= r_key_sh;
`endif
            end
            if (w_spr_sel) begin
                case (w_wr_field)
                    3'd0: r_shadow[w_wr_idx].sx <= bus.wdata;
                    3'd1: r_shadow[w_wr_idx].sy <= bus.wdata;
                    3'd2: r_shadow[w_wr_idx].tx <= bus.wdata;
                    3'd3: r_shadow[w_wr_idx].ty <= bus.wdata;
                    3'd4: r_shadow[w_wr_idx].tw <= bus.wdata;
                    3'd5: r_shadow[w_wr_idx].th <= bus.wdata;
                    3'd6: begin
                        r_shadow[w_wr_idx].en     <= bus.wdata[0];
                        r_shadow[w_wr_idx].scale  <= bus.wdata[2:1];
                        r_shadow[w_wr_idx].flip_x <= bus.wdata[3];
                        r_shadow[w_wr_idx].flip_y <= bus.wdata[4];
                    end
                    default: ;
                endcase
            end
            if (w_bg_sel) begin
                r_bg_sh <= bus.wdata[COLOR_WIDTH-1:0];
            end
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
            if (w_key_sel) begin
                r_key_sh <= bus.wdata[COLOR_WIDTH-1:0];
            end
`endif
        end
    end

    // ---------------- texture RAM ----------------
    logic [COLOR_WIDTH-1:0] r_tex [TEX_DEPTH];

    // Texture writes land immediately; contents survive reset
    always_ff @(posedge clk) begin
        if (w_tex_sel) begin
            r_tex[w_tex_off[RA_W-1:0]] <= bus.wdata[COLOR_WIDTH-1:0];
        end
    end

    // ---------------- S1: hit test ----------------
    logic signed [EXT_W-1:0] w_x_e;
    logic signed [EXT_W-1:0] w_y_e;
    logic [NUM_SPRITES-1:0]  w_hit;
    logic [INT_WIDTH-1:0]    w_dx_all [NUM_SPRITES];
    logic [INT_WIDTH-1:0]    w_dy_all [NUM_SPRITES];

    assign w_x_e = {{EXT_PAD{1'b0}}, bus.x};
    assign w_y_e = {{EXT_PAD{1'b0}}, bus.y};

    // Widened compares: offsets relative to the sprite origin must be
    // non-negative and below the scaled extent
    for (genvar g = 0; g < int'(NUM_SPRITES); g++) begin : g_hit
        logic signed [EXT_W-1:0] w_sx_e;
        logic signed [EXT_W-1:0] w_sy_e;
        logic signed [EXT_W-1:0] w_rel_x;
        logic signed [EXT_W-1:0] w_rel_y;
        logic [EXT_W-1:0]        w_span_x;
        logic [EXT_W-1:0]        w_span_y;

        assign w_sx_e   = {{EXT_PAD{r_active[g].sx[INT_WIDTH-1]}}, r_active[g].sx};
        assign w_sy_e   = {{EXT_PAD{r_active[g].sy[INT_WIDTH-1]}}, r_active[g].sy};
        assign w_span_x = {{EXT_PAD{1'b0}}, r_active[g].tw} << r_active[g].scale;
        assign w_span_y = {{EXT_PAD{1'b0}}, r_active[g].th} << r_active[g].scale;
        assign w_rel_x  = w_x_e - w_sx_e;
        assign w_rel_y  = w_y_e - w_sy_e;

        assign w_hit[g] = r_active[g].en
                          && !w_rel_x[EXT_W-1] && (w_rel_x < signed'(w_span_x))
                          && !w_rel_y[EXT_W-1] && (w_rel_y < signed'(w_span_y));
        assign w_dx_all[g] = INT_WIDTH'(unsigned'(w_rel_x) >> r_active[g].scale);
        assign w_dy_all[g] = INT_WIDTH'(unsigned'(w_rel_y) >> r_active[g].scale);
    end

    logic             w_hit_any;
    logic [IDX_W-1:0] w_sel;

    // Fixed priority: lowest-index hitting sprite wins
    always_comb begin
        w_hit_any = |w_hit;
        w_sel     = '0;
        for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel = IDX_W'(i);
            end
        end
    end

    logic                   r1_valid;
    logic                   r1_hit;
    logic [INT_WIDTH-1:0]   r1_dx;
    logic [INT_WIDTH-1:0]   r1_dy;
    logic [INT_WIDTH-1:0]   r1_tx;
    logic [INT_WIDTH-1:0]   r1_ty;
    logic [INT_WIDTH-1:0]   r1_tw;
    logic [INT_WIDTH-1:0]   r1_th;
    logic                   r1_fx;
    logic                   r1_fy;
    logic [COLOR_WIDTH-1:0] r1_bg;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
    logic [COLOR_WIDTH-1:0] r1_key;
`endif

    // Capture the winning sprite's geometry so later commits cannot touch it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_valid <= 1'b0;
            r1_hit   <= 1'b0;
            r1_dx    <= '0;
            r1_dy    <= '0;
            r1_tx    <= '0;
            r1_ty    <= '0;
            r1_tw    <= '0;
            r1_th    <= '0;
            r1_fx    <= 1'b0;
            r1_fy    <= 1'b0;
            r1_bg    <= '0;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
            r1_key   <= '0;
`endif
        end else begin
            r1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r1_hit <= w_hit_any;
                r1_dx  <= w_dx_all[w_sel];
                r1_dy  <= w_dy_all[w_sel];
                r1_tx  <= r_active[w_sel].tx;
                r1_ty  <= r_active[w_sel].ty;
                r1_tw  <= r_active[w_sel].tw;
                r1_th  <= r_active[w_sel].th;
                r1_fx  <= r_active[w_sel].flip_x;
                r1_fy  <= r_active[w_sel].flip_y;
                r1_bg  <= r_bg_act;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
                r1_key <= r_key_act;
`endif
            end
        end
    end

    // ---------------- S2: texel address ----------------
    logic [INT_WIDTH-1:0] w_u;
    logic [INT_WIDTH-1:0] w_v;
    logic [RA_W-1:0]      w_raddr;

    assign w_u     = r1_fx ? (r1_tw - INT_WIDTH'(1) - r1_dx) : r1_dx;
    assign w_v     = r1_fy ? (r1_th - INT_WIDTH'(1) - r1_dy) : r1_dy;
    assign w_raddr = RA_W'((r1_ty + w_v) * INT_WIDTH'(TEXTURE_WIDTH) + (r1_tx + w_u));

    logic                   r2_valid;
    logic                   r2_hit;
    logic [RA_W-1:0]        r2_raddr;
    logic [COLOR_WIDTH-1:0] r2_bg;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
    logic [COLOR_WIDTH-1:0] r2_key;
`endif

    // Register the texel address alongside hit and background
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r2_valid <= 1'b0;
            r2_hit   <= 1'b0;
            r2_raddr <= '0;
            r2_bg    <= '0;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
            r2_key   <= '0;
`endif
        end else begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_hit   <= r1_hit;
                r2_raddr <= w_raddr;
                r2_bg    <= r1_bg;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
                r2_key   <= r1_key;
`endif
            end
        end
    end

    // ---------------- S3: texture read and compose ----------------
    logic [COLOR_WIDTH-1:0] w_texel;
    logic                   w_opaque;

    assign w_texel = r_tex[r2_raddr];
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
    assign w_opaque = (w_texel != r2_key);
`else
    assign w_opaque = 1'b1;
`endif

    logic                   r3_valid;
    logic [COLOR_WIDTH-1:0] r_pixel;

    // Pixel updates only for valid slots and holds across bubbles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r3_valid <= 1'b0;
            r_pixel  <= '0;
        end else begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r_pixel <= (r2_hit && w_opaque) ? w_texel : r2_bg;
            end
        end
    end

    assign bus.out_valid = r3_valid;
    assign bus.pixel     = r_pixel;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine with a behavioural reference model and
// an expected-pixel queue checked as pixels emerge.
`timescale 1ns/1ps
module tb_sprite_engine;

    localparam int NS       = 16;
    localparam int TW       = 64;
    localparam int TH       = 64;
    localparam int DEPTH    = TW * TH;
    localparam int BG_ADDR  = NS * 8;
    localparam int TEX_BASE = BG_ADDR + 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sprite_engine_if #(.ADDR_WIDTH(16), .INT_WIDTH(16), .COLOR_WIDTH(12)) bus ();

    sprite_engine #(
        .NUM_SPRITES(NS), .TEXTURE_WIDTH(TW), .TEXTURE_HEIGHT(TH),
        .ADDR_WIDTH(16), .INT_WIDTH(16), .COLOR_WIDTH(12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    logic [15:0] m_sh  [NS][8];
    logic [15:0] m_act [NS][8];
    logic [11:0] m_bg_sh, m_bg_act;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
    logic [11:0] m_key_sh, m_key_act;
`endif
    logic [11:0] m_tex [DEPTH];

    typedef struct packed {
        logic [11:0] pix;
        logic [31:0] cyc;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    logic [11:0] last_pix = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] model_px(input int px, input int py);
        int sx, sy, s, tw, th, tx, ty, dx, dy, u, v, a;
        logic [11:0] res;
        bit found;
        found = 0;
        res   = m_bg_act;
        for (int i = 0; i < NS; i++) begin
            sx = int'($signed(m_act[i][0]));
            sy = int'($signed(m_act[i][1]));
            tx = int'(m_act[i][2]);
            ty = int'(m_act[i][3]);
            tw = int'(m_act[i][4]);
            th = int'(m_act[i][5]);
            s  = int'(m_act[i][6][2:1]);
            if (!found && m_act[i][6][0] &&
                px >= sx && px < sx + (tw << s) && py >= sy && py < sy + (th << s)) begin
                found = 1;
                dx = (px - sx) >> s;
                dy = (py - sy) >> s;
                u  = m_act[i][6][3] ? tw - 1 - dx : dx;
                v  = m_act[i][6][4] ? th - 1 - dy : dy;
                a  = ((ty + v) * TW + tx + u) & (DEPTH - 1);
                res = m_tex[a];
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
                if (res == m_key_act) res = m_bg_act;
`endif
            end
        end
        return res;
    endfunction

    task automatic model_write(input int a, input int d);
        if (a < BG_ADDR) m_sh[a / 8][a % 8] = 16'(d);
        else if (a == BG_ADDR) m_bg_sh = 12'(d);
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
        else if (a == BG_ADDR + 1) m_key_sh = 12'(d);
`endif
        else if (a >= TEX_BASE && a < TEX_BASE + DEPTH) m_tex[a - TEX_BASE] = 12'(d);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++)
            for (int f = 0; f < 8; f++) begin
                m_sh[i][f]  = '0;
                m_act[i][f] = '0;
            end
        m_bg_sh  = '0;
        m_bg_act = '0;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
        m_key_sh  = '0;
        m_key_act = '0;
`endif
    endtask

    // One clock: drive inputs, update model, then check what the DUT emits
    task automatic step(input bit v, input int px, input int py,
                        input bit we, input int a, input int d, input bit cm);
        exp_t e;
        bus.in_valid = v;
        bus.x        = 16'(px);
        bus.y        = 16'(py);
        bus.wen      = we;
        bus.waddr    = 16'(a);
        bus.wdata    = 16'(d);
        bus.commit   = cm;
        if (v) sb.push_back('{pix: model_px(px, py), cyc: cyc + 3});
        if (cm) begin
            m_act    = m_sh;
            m_bg_act = m_bg_sh;
`ifdef SPRITE_ENGINE_COLOR_KEY_EN
            m_key_act = m_key_sh;
`endif
        end
        if (we) model_write(a, d);
        @(posedge clk);
        #1;
        if (bus.out_valid === 1'b1) begin
            chk("out_valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pixel", 32'(bus.pixel), 32'(e.pix));
                chk("latency_cycle", cyc, e.cyc);
                last_pix = e.pix;
            end
        end else begin
            if (sb.size() != 0 && sb[0].cyc <= cyc)
                chk("missing_out_valid", 32'(bus.out_valid), 32'd1);
            chk("pixel_hold", 32'(bus.pixel), 32'(last_pix));
        end
    endtask

    task automatic wr(input int a, input int d);
        step(0, 0, 0, 1, a, d, 0);
    endtask

    task automatic commit_regs();
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic coord(input int px, input int py);
        step(1, px, py, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_sprite(input int i, input int sx, input int sy, input int tx,
                              input int ty, input int tw, input int th, input int attr);
        wr(i * 8 + 0, sx);
        wr(i * 8 + 1, sy);
        wr(i * 8 + 2, tx);
        wr(i * 8 + 3, ty);
        wr(i * 8 + 4, tw);
        wr(i * 8 + 5, th);
        wr(i * 8 + 6, attr);
    endtask

    initial begin
        bus.in_valid = 0; bus.x = '0; bus.y = '0;
        bus.wen = 0; bus.waddr = '0; bus.wdata = '0; bus.commit = 0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_pixel", 32'(bus.pixel), 32'd0);
        rst = 1'b1;

        // fill the whole texture with a known pattern, then one out-of-range write
        for (int i = 0; i < DEPTH; i++) wr(TEX_BASE + i, (i * 37 + 5) & 'hfff);
        wr(TEX_BASE + DEPTH, 'heee);

        // no sprites: black background, then background without and with commit
        for (int i = 0; i < 10; i++) coord(i, 0);
        wr(BG_ADDR, 'habc);
        for (int i = 0; i < 3; i++) coord(i, 0);
        commit_regs();
        for (int i = 0; i < 10; i++) coord(i, 0);

        // sprite 0 at (10,20), 4x4 scaled by 2, texel (1,2)=0x123
        wr(TEX_BASE + 2 * TW + 1, 'h123);
        set_sprite(0, 10, 20, 0, 0, 4, 4, 'h3);
        wr(7, 'hffff);
        commit_regs();
        coord(13, 24); coord(18, 20); coord(9, 20); coord(17, 27); coord(10, 20);

        // texel 0 through a 1x1 sprite: out-of-range write must not alias it
        set_sprite(7, 300, 300, 0, 0, 1, 1, 'h1);
        commit_regs();
        coord(300, 300);

        // overlap priority: sprites 2 and 5 both cover (30,30)
        wr(TEX_BASE + 2 * TW + 10, 'h222);
        wr(TEX_BASE + 1 * TW + 17, 'h555);
        set_sprite(2, 28, 28, 8, 0, 4, 4, 'h1);
        set_sprite(5, 29, 29, 16, 0, 4, 4, 'h1);
        commit_regs();
        coord(30, 30);
        wr(2 * 8 + 6, 'h0);
        commit_regs();
        coord(30, 30);

        // flips on an 8x8 sprite at x=0
        set_sprite(1, 0, 40, 32, 8, 8, 8, 'h9);
        commit_regs();
        coord(0, 40); coord(3, 42); coord(7, 47);
        wr(1 * 8 + 6, 'h19);
        commit_regs();
        coord(0, 40); coord(3, 42);

        // negative origin clipping and zero-size sprites
        set_sprite(3, 'hfffd, 'hfffe, 40, 40, 4, 4, 'h1);
        set_sprite(6, 200, 200, 0, 0, 0, 4, 'h1);
        set_sprite(8, 210, 200, 0, 0, 4, 0, 'h1);
        commit_regs();
        coord(0, 0); coord(0, 1); coord(0, 2); coord(1, 0);
        coord(200, 200); coord(210, 200);

        // shadow only, then write+commit in the same cycle, then commit again
        wr(0, 50);
        coord(13, 24);
        step(0, 0, 0, 1, 0, 70, 1);
        coord(13, 24); coord(53, 24);
        commit_regs();
        coord(73, 24); coord(53, 24);

        // commit in the middle of a coordinate stream
        wr(0, 10);
        coord(13, 24);
        step(1, 13, 24, 0, 0, 0, 1);
        coord(13, 24); coord(13, 24);

        // colour key: key 0xF0F on sprite 0 texel
        wr(BG_ADDR + 1, 'hf0f);
        wr(TEX_BASE + 2 * TW + 1, 'hf0f);
        idle(3);
        coord(13, 24);
        commit_regs();
        coord(13, 24); coord(12, 22);
        idle(4);

        // reset in the middle of a stream
        coord(13, 24); coord(0, 40); coord(30, 30);
        bus.in_valid = 0; bus.wen = 0; bus.commit = 0;
        rst = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset_pixel", 32'(bus.pixel), 32'd0);
        sb.delete();
        model_reset();
        last_pix = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // after reset: everything cleared, texture retained
        coord(13, 24); coord(0, 40); coord(30, 30);
        set_sprite(0, 10, 20, 0, 0, 4, 4, 'h3);
        commit_regs();
        coord(13, 24); coord(11, 21);

        // drain and confirm nothing is left outstanding
        idle(6);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("final_pixel_hold", 32'(bus.pixel), 32'(last_pix));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
